ffo_set_bit_scanner: RTL and testbench

//  Sequencer around an N-bit find-first-one datapath. It captures a bit vector on start,

---
 rtl/ffo_set_bit_scanner.sv | 87 ++++++++
 tb/tb_ffo_set_bit_scanner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ffo_set_bit_scanner.sv
// Set-bit scanner: captures a vector on start and reports each set index, lowest first, one per ack.
// Optional FFO_SCAN_COUNT_EN adds a count of indices acknowledged in the current/last scan.
module ffo_set_bit_scanner #(
   parameter  int N  = 32,
   localparam int PW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [0:N-1]  b,
   input  logic          abort,
   output logic          ready,
   output logic          pos_valid,
   output logic [0:PW-1] pos,
   input  logic          pos_ack,
   output logic          done
`ifdef FFO_SCAN_COUNT_EN
   ,
   output logic [PW:0]   count
`endif
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state;
   logic [0:N-1]  mask;
   logic          ffo_v;
   logic [0:PW-1] ffo_p;

   // Downward sweep so the lowest set index is the one left in ffo_p.
   always_comb begin
      ffo_v = |mask;
      ffo_p = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) ffo_p = PW'(i);
      end
   end

   assign ready     = (state == IDLE);
   assign pos_valid = (state == SCAN) && ffo_v;
   assign done      = (state == SCAN) && !ffo_v;
   assign pos       = pos_valid ? ffo_p : '0;

`ifdef FFO_SCAN_COUNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (state == IDLE) begin
         if (start) count <= '0;
      end else if (!abort && ffo_v && pos_ack) begin
         count <= count + (PW+1)'(1);
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         mask  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mask  <= b;
                  state <= SCAN;
               end
            end
            SCAN: begin
               // Abort takes priority over an ack in the same cycle.
               if (abort) begin
                  mask  <= '0;
                  state <= IDLE;
               end else if (!ffo_v) begin
                  state <= IDLE;
               end else if (pos_ack) begin
                  mask[ffo_p] <= 1'b0;
               end
            end
            default: begin
               mask  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ffo_set_bit_scanner.sv
// Bench for ffo_set_bit_scanner: directed scenarios plus random scans against a queue-of-indices model.
module tb_ffo_set_bit_scanner;

   localparam int N  = 32;
   localparam int PW = $clog2(N);

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [0:N-1]  b;
   logic          abort;
   logic          ready;
   logic          pos_valid;
   logic [0:PW-1] pos;
   logic          pos_ack;
   logic          done;
`ifdef FFO_SCAN_COUNT_EN
   logic [PW:0]   count;
`endif

   ffo_set_bit_scanner #(.N(N)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .b(b), .abort(abort),
      .ready(ready), .pos_valid(pos_valid), .pos(pos), .pos_ack(pos_ack), .done(done)
`ifdef FFO_SCAN_COUNT_EN
      , .count(count)
`endif
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // Model: pending indices of the captured vector, lowest first.
   int q[$];
   bit m_busy = 0;
   int m_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string ph);
      logic pv;
      pv = m_busy && (q.size() > 0);
      chk({ph, ".ready"},     32'(ready),     32'(!m_busy));
      chk({ph, ".pos_valid"}, 32'(pos_valid), 32'(pv));
      chk({ph, ".done"},      32'(done),      32'(m_busy && q.size() == 0));
      chk({ph, ".pos"},       32'(pos),       pv ? 32'(q[0]) : 32'd0);
`ifdef FFO_SCAN_COUNT_EN
      chk({ph, ".count"},     32'(count),     32'(m_cnt));
`endif
   endtask

   // One clock: check the current outputs, drive inputs for the coming edge, advance the model.
   task automatic cycle(input string ph, input logic st, input logic ab, input logic ak,
                        input logic [0:N-1] bv);
      @(negedge clock);
      check_outputs(ph);
      start = st; abort = ab; pos_ack = ak; b = bv;
      if (!m_busy) begin
         if (st) begin
            q.delete();
            for (int i = 0; i < N; i++) if (bv[i]) q.push_back(i);
            m_busy = 1;
            m_cnt  = 0;
         end
      end else if (ab) begin
         m_busy = 0;
         q.delete();
      end else if (q.size() == 0) begin
         m_busy = 0;
      end else if (ak) begin
         void'(q.pop_front());
         m_cnt++;
      end
   endtask

   task automatic run_scan(input string ph, input logic [0:N-1] v, input int ack_pct,
                           input int abort_pct, input bit noise);
      int n;
      cycle(ph, 1'b1, 1'b0, 1'b0, v);
      n = 0;
      while (m_busy && n < 300) begin
         cycle(ph, noise && ($urandom_range(7) == 0),
               $urandom_range(99) < abort_pct,
               $urandom_range(99) < ack_pct,
               noise ? N'($urandom) : v);
         n++;
      end
      chk({ph, ".bound"}, 32'(n < 300), 32'd1);
      cycle(ph, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [0:N-1] v;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; pos_ack = 1'b0; b = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check_outputs("reset");

      // Two set bits, ack held: pos 0, pos 31, done, ready.
      cycle("t2", 1'b1, 1'b0, 1'b1, 32'h8000_0001);
      repeat (4) cycle("t2", 1'b0, 1'b0, 1'b1, '0);

      // Empty vector.
      cycle("t3", 1'b1, 1'b0, 1'b0, '0);
      repeat (3) cycle("t3", 1'b0, 1'b0, 1'b1, '0);

      // All ones, ack held off for three cycles.
      cycle("t4", 1'b1, 1'b0, 1'b0, '1);
      repeat (3) cycle("t4", 1'b0, 1'b0, 1'b0, '0);
      repeat (34) cycle("t4", 1'b0, 1'b0, 1'b1, '0);
`ifdef FFO_SCAN_COUNT_EN
      chk("t4.final_count", 32'(count), 32'd32);
`endif

      // Start and b changes mid-scan are ignored.
      cycle("t5", 1'b1, 1'b0, 1'b1, 32'h1234_5678);
      repeat (3) cycle("t5", 1'b0, 1'b0, 1'b1, '0);
      cycle("t5", 1'b1, 1'b0, 1'b1, 32'hFFFF_0000);
      repeat (14) cycle("t5", 1'b0, 1'b0, 1'b1, 32'hFFFF_0000);

      // Abort together with ack on the first index.
      cycle("t6", 1'b1, 1'b0, 1'b0, 32'h0F00_0000);
      cycle("t6", 1'b0, 1'b1, 1'b1, '0);
      repeat (2) cycle("t6", 1'b0, 1'b0, 1'b1, '0);

      // Abort in IDLE alongside start: start is accepted.
      cycle("t7", 1'b1, 1'b1, 1'b1, 32'h0000_00C0);
      repeat (4) cycle("t7", 1'b0, 1'b0, 1'b1, '0);

      // Asynchronous reset mid-scan.
      cycle("t8", 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
      repeat (3) cycle("t8", 1'b0, 1'b0, 1'b1, '0);
      #2 reset_n = 1'b0;
      m_busy = 0; m_cnt = 0; q.delete();
      #1 check_outputs("t8.async");
      @(negedge clock);
      start = 1'b0; abort = 1'b0; pos_ack = 1'b0;
      reset_n = 1'b1;
      cycle("t8.post", 1'b0, 1'b0, 1'b0, '0);

      // Random scans with random ack, noise on start/b and occasional abort.
      for (int r = 0; r < 60; r++) begin
         v = N'($urandom);
         if (r % 3 == 1) v = v & N'($urandom) & N'($urandom);
         run_scan("rand", v, 30 + $urandom_range(70), (r % 4 == 3) ? 8 : 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
